// File: rtl/clock_pio_pkg.sv
// Shared definitions for the clock's Avalon-MM PIO blocks: register map and edge-type encodings.
package clock_pio_pkg;

  localparam logic [1:0] PIO_DATA    = 2'd0;
  localparam logic [1:0] PIO_RSVD    = 2'd1;
  localparam logic [1:0] PIO_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Unknown encodings fall back to rising-edge detection.
  function automatic logic edge_sel(input int edge_type, input logic cur, input logic prev);
    case (edge_type)
      EDGE_FALL: edge_sel = ~cur & prev;
      EDGE_ANY:  edge_sel = cur ^ prev;
      default:   edge_sel = cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/clock_button_debounce.sv
// One button bit: 2-flop synchronizer, stability counter, debounced level and edge pulse.
// db changes DEBOUNCE_CYCLES cycles after s2 settles; edge_pulse is high for the cycle after db changes.
module clock_button_debounce
  import clock_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   EDGE_TYPE       = EDGE_FALL,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic db,
  output logic edge_pulse
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          db_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= IDLE_LEVEL;
      s2   <= IDLE_LEVEL;
      db   <= IDLE_LEVEL;
      db_d <= IDLE_LEVEL;
      cnt  <= '0;
    end else begin
      s1   <= pin;
      s2   <= s1;
      db_d <= db;
      // Any return to the debounced level restarts the stability count.
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign edge_pulse = edge_sel(EDGE_TYPE, db, db_d);

endmodule

// File: rtl/clock_button_pio.sv
// Avalon-MM button PIO: debounced data, irq mask and write-1-to-clear edge capture; zero-wait-state reads.
// Captured edges are ORed into irq through the mask; a set in the same cycle as a clear wins.
module clock_button_pio
  import clock_pio_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   EDGE_TYPE       = EDGE_FALL,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] clr_mask;
  logic             wr_en;
  logic             unused_wr_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    clock_button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE      (EDGE_TYPE),
      .IDLE_LEVEL     (IDLE_LEVEL)
    ) u_debounce (
      .clk       (clk),
      .reset_n   (reset_n),
      .pin       (in_port[i]),
      .db        (db[i]),
      .edge_pulse(edge_hit[i])
    );
  end

  assign wr_en    = chipselect && !write_n;
  assign clr_mask = (wr_en && address == PIO_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // Write data above WIDTH has no register behind it.
  assign unused_wr_bits = ^{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      if (wr_en && address == PIO_IRQMASK) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      edgecap <= (edgecap & ~clr_mask) | edge_hit;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      PIO_DATA:    readdata[WIDTH-1:0] = db;
      PIO_IRQMASK: readdata[WIDTH-1:0] = irqmask;
      PIO_EDGECAP: readdata[WIDTH-1:0] = edgecap;
      default:     readdata = '0;
    endcase
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_clock_button_pio.sv
// Directed bench for clock_button_pio with DEBOUNCE_CYCLES=4, WIDTH=4, falling-edge capture.
module tb_clock_button_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  clock_button_pio #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE      (1),
    .IDLE_LEVEL     (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    address = addr;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic irq_check(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  // Drives one write cycle; returns at the negedge after the write edge.
  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state and reserved/RO addresses
    rd_check("rst_data", 2'd0, 32'h0000_000F);
    rd_check("rst_mask", 2'd2, 32'h0);
    rd_check("rst_ecap", 2'd3, 32'h0);
    irq_check("rst_irq", 1'b0);
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'h0000_0000);
    rd_check("rsvd_read", 2'd1, 32'h0);
    rd_check("data_ro", 2'd0, 32'h0000_000F);

    // Press bit 0: db at edge 6, capture at edge 7
    @(negedge clk);
    in_port = 4'hE;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rd_check("data_edge5", 2'd0, 32'h0000_000F);
    @(posedge clk);
    @(negedge clk);
    rd_check("data_edge6", 2'd0, 32'h0000_000E);
    rd_check("ecap_edge6", 2'd3, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rd_check("ecap_edge7", 2'd3, 32'h1);
    irq_check("irq_masked", 1'b0);

    // Clear, rising edge ignored, then masked press raises irq
    wr(2'd3, 32'h1);
    rd_check("ecap_clr0", 2'd3, 32'h0);
    @(negedge clk);
    in_port = 4'hF;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rd_check("data_release", 2'd0, 32'h0000_000F);
    rd_check("ecap_no_rise", 2'd3, 32'h0);
    wr(2'd2, 32'hFFFF_FFF1);
    rd_check("mask_rd", 2'd2, 32'h1);
    irq_check("irq_empty", 1'b0);
    @(negedge clk);
    in_port = 4'hE;
    repeat (7) @(posedge clk);
    @(negedge clk);
    irq_check("irq_set", 1'b1);
    rd_check("ecap_b0", 2'd3, 32'h1);
    wr(2'd3, 32'h1);
    rd_check("ecap_clr1", 2'd3, 32'h0);
    irq_check("irq_clr", 1'b0);

    // Bit 1 bounces with a 3-cycle period, then holds low
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rd_check("bounce_data", 2'd0, 32'h0000_000E);
      in_port[1] = (k % 3 == 2);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      rd_check("settle_data", 2'd0, 32'h0000_000E);
    end
    @(negedge clk);
    rd_check("settled_data", 2'd0, 32'h0000_000C);
    rd_check("settled_ecap", 2'd3, 32'h0);
    @(negedge clk);
    rd_check("bounce_ecap", 2'd3, 32'h2);
    irq_check("bounce_irq", 1'b0);

    // Bit 2 falling edge captured in the same cycle as its clear
    @(negedge clk);
    in_port[2] = 1'b0;
    repeat (6) @(posedge clk);
    wr(2'd3, 32'h4);
    rd_check("set_wins", 2'd3, 32'h6);
    rd_check("data_b2", 2'd0, 32'h0000_0008);
    wr(2'd3, 32'h4);
    rd_check("clr_b2", 2'd3, 32'h2);
    wr(2'd3, 32'hF);
    rd_check("clr_all", 2'd3, 32'h0);

    // Build edgecapture = 0x3, then reset mid-count on bit 3
    @(negedge clk);
    in_port = 4'hF;
    repeat (10) @(posedge clk);
    wr(2'd2, 32'h3);
    @(negedge clk);
    in_port = 4'hC;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rd_check("pre_rst_ecap", 2'd3, 32'h3);
    irq_check("pre_rst_irq", 1'b1);
    in_port = 4'h4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    in_port = 4'hF;
    rd_check("in_rst_data", 2'd0, 32'h0000_000F);
    rd_check("in_rst_mask", 2'd2, 32'h0);
    rd_check("in_rst_ecap", 2'd3, 32'h0);
    irq_check("in_rst_irq", 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      irq_check("post_rst_irq", 1'b0);
    end
    rd_check("post_rst_data", 2'd0, 32'h0000_000F);
    rd_check("post_rst_mask", 2'd2, 32'h0);
    rd_check("post_rst_ecap", 2'd3, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
